// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port frame-buffer arbiter with priority
// display read > clear engine > write port.
// Ports: clk/rst (sync, active-high); vga_en/vga_x/vga_y scanner in,
// rgb registered pixel out; wr_req/wr_x/wr_y/wr_data in with wr_ack;
// clr_start/clr_color in with busy/clr_done; mem_addr/mem_we/mem_wdata
// out and mem_rdata in (synchronous read, one-cycle latency).
module vram_arbiter #(
    parameter int FB_W = 256,
    parameter int FB_H = 256,
    parameter int DW   = 12,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_en,
    input  logic [15:0]   vga_x,
    input  logic [15:0]   vga_y,
    output logic [DW-1:0] rgb,
    input  logic          wr_req,
    input  logic [15:0]   wr_x,
    input  logic [15:0]   wr_y,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          busy,
    output logic          clr_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int XSH  = $clog2(FB_W);
    localparam int NPIX = FB_W * FB_H;
    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [32:0]   prev_q, prev_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] color_q, color_d;
    logic          rd_v_q, rd_v_d;
    logic          rd_blank_q, rd_blank_d;
    logic [DW-1:0] rgb_q, rgb_d;
    logic          done_q, done_d;

    logic [32:0]   cur;
    logic          disp_req;
    logic          disp_in;

    function automatic logic in_fb(input logic [15:0] x,
                                   input logic [15:0] y);
        return ({1'b0, x} < 17'(FB_W)) && ({1'b0, y} < 17'(FB_H));
    endfunction

    // y*FB_W as a shift; FB_W is a power of two
    function automatic logic [AW-1:0] pix_addr(input logic [15:0] x,
                                               input logic [15:0] y);
        logic [31:0] a;
        a = (32'(y) << XSH) + 32'(x);
        return a[AW-1:0];
    endfunction

    assign cur      = {vga_en, vga_x, vga_y};
    assign disp_req = (cur != prev_q);
    assign disp_in  = vga_en && in_fb(vga_x, vga_y);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        ptr_d      = ptr_q;
        color_d    = color_q;
        rd_v_d     = 1'b0;
        rd_blank_d = rd_blank_q;
        rgb_d      = rgb_q;
        done_d     = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        wr_ack     = 1'b0;

        if (rd_v_q) begin
            rgb_d = rd_blank_q ? '0 : mem_rdata;
        end

        // display owns the port for any cycle the scanner moves
        if (disp_req) begin
            prev_d     = cur;
            rd_v_d     = 1'b1;
            rd_blank_d = !disp_in;
            if (disp_in) begin
                mem_addr = pix_addr(vga_x, vga_y);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                    color_d = clr_color;
                end else if (wr_req && !disp_req) begin
                    wr_ack = 1'b1;
                    if (in_fb(wr_x, wr_y)) begin
                        mem_we    = 1'b1;
                        mem_addr  = pix_addr(wr_x, wr_y);
                        mem_wdata = wr_data;
                    end
                end
            end
            S_CLEAR: begin
                if (!disp_req) begin
                    mem_we    = 1'b1;
                    mem_addr  = ptr_q;
                    mem_wdata = color_q;
                    ptr_d     = ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        // keep the memory port quiet while reset is held
        if (rst) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
            wr_ack    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            ptr_q      <= '0;
            color_q    <= '0;
            rd_v_q     <= 1'b0;
            rd_blank_q <= 1'b0;
            rgb_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            ptr_q      <= ptr_d;
            color_q    <= color_d;
            rd_v_q     <= rd_v_d;
            rd_blank_q <= rd_blank_d;
            rgb_q      <= rgb_d;
            done_q     <= done_d;
        end
    end

    assign rgb      = rgb_q;
    assign busy     = (state_q == S_CLEAR);
    assign clr_done = done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a
// synchronous-read memory model attached to the memory port.
module tb_vram_arbiter;

    localparam int DW = 12;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vga_en = 1'b0;
    logic [15:0]   vga_x = '0;
    logic [15:0]   vga_y = '0;
    logic [DW-1:0] rgb;
    logic          wr_req = 1'b0;
    logic [15:0]   wr_x = '0;
    logic [15:0]   wr_y = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          busy;
    logic          clr_done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    vram_arbiter #(.FB_W(256), .FB_H(256), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .vga_en(vga_en), .vga_x(vga_x), .vga_y(vga_y), .rgb(rgb),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_color(clr_color),
        .busy(busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [65536];
    bit init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= '0;
            mem[773] <= 12'hABC;
            mem[774] <= 12'h123;
            init_done <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        bit ack;
        bit we;
        int addr;
        int data;
        bit done;
    } bus_t;

    typedef struct {
        int cyc;
        int sel;
        int val;
    } chk_t;

    bus_t bus_q[$];
    chk_t chk_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int sig_val(int sel);
        case (sel)
            0: return 32'(rgb);
            1: return 32'(mem_addr);
            2: return 32'(mem_we);
            3: return 32'(wr_ack);
            4: return 32'(busy);
            5: return 32'(clr_done);
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(int sel);
        case (sel)
            0: return "rgb";
            1: return "mem_addr";
            2: return "mem_we";
            3: return "wr_ack";
            4: return "busy";
            5: return "clr_done";
            default: return "unknown";
        endcase
    endfunction

    task automatic cmp(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk(int c, int sel, int val);
        chk_t t;
        t.cyc = c;
        t.sel = sel;
        t.val = val;
        chk_q.push_back(t);
    endtask

    task automatic exp_bus(bit ack, bit we, int addr, int data, bit done);
        bus_t b;
        b.ack  = ack;
        b.we   = we;
        b.addr = addr;
        b.data = data;
        b.done = done;
        bus_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: scheduled signal checks plus bus-event scoreboard
    always @(negedge clk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                cmp(sig_name(chk_q[i].sel), sig_val(chk_q[i].sel),
                    chk_q[i].val);
                chk_q.delete(i);
            end
        end
        if (mem_we || wr_ack || clr_done) begin
            if (bus_q.size() == 0) begin
                cmp("bus_unexpected", 1, 0);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                cmp("bus_ack", 32'(wr_ack), 32'(e.ack));
                cmp("bus_we", 32'(mem_we), 32'(e.we));
                cmp("bus_done", 32'(clr_done), 32'(e.done));
                if (e.we) begin
                    cmp("bus_addr", 32'(mem_addr), e.addr);
                    cmp("bus_wdata", 32'(mem_wdata), e.data);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;
        repeat (3) tick();
        rst = 1'b0;
        c = cyc;
        for (int s = 0; s < 6; s++) chk(c, s, 0);
        tick(); tick();

        // in-area display read
        vga_en = 1'b1; vga_x = 16'd5; vga_y = 16'd3;
        c = cyc;
        chk(c, 1, 773); chk(c, 2, 0);
        chk(c + 1, 0, 0); chk(c + 2, 0, 'hABC);
        repeat (4) tick();

        // out-of-area display: blank pixel
        vga_x = 16'd300; vga_y = 16'd10;
        c = cyc;
        chk(c, 2, 0); chk(c, 3, 0);
        chk(c + 1, 0, 'hABC); chk(c + 2, 0, 0);
        repeat (4) tick();

        // write collides with display, served next cycle
        vga_x = 16'd6; vga_y = 16'd3;
        wr_req = 1'b1; wr_x = 16'd1; wr_y = 16'd2; wr_data = 12'h0F0;
        c = cyc;
        chk(c, 3, 0); chk(c, 1, 774); chk(c + 1, 3, 1);
        chk(c + 2, 0, 'h123);
        exp_bus(1, 1, 513, 'h0F0, 0);
        tick(); tick();
        wr_req = 1'b0;
        chk(cyc, 3, 0);
        tick(); tick();

        // read back the written pixel
        vga_x = 16'd1; vga_y = 16'd2;
        c = cyc;
        chk(c, 1, 513); chk(c + 2, 0, 'h0F0);
        repeat (4) tick();

        // out-of-range writes are acked and dropped
        wr_req = 1'b1; wr_x = 16'd256; wr_y = 16'd0; wr_data = 12'h555;
        chk(cyc, 3, 1); chk(cyc, 2, 0);
        exp_bus(1, 0, 0, 0, 0);
        tick();
        wr_req = 1'b0;
        chk(cyc, 3, 0);
        tick();
        wr_req = 1'b1; wr_x = 16'd0; wr_y = 16'd256;
        chk(cyc, 3, 1); chk(cyc, 2, 0);
        exp_bus(1, 0, 0, 0, 0);
        tick();
        wr_req = 1'b0;
        tick(); tick();

        // full clear with a write held throughout
        clr_start = 1'b1; clr_color = 12'h00F;
        wr_req = 1'b1; wr_x = 16'd3; wr_y = 16'd4; wr_data = 12'h777;
        c = cyc;
        chk(c, 3, 0); chk(c, 4, 0); chk(c + 1, 4, 1);
        chk(c + 65536, 4, 1); chk(c + 65536, 5, 0);
        chk(c + 65537, 4, 0); chk(c + 65537, 5, 1);
        chk(c + 65538, 5, 0); chk(c + 65538, 3, 0);
        for (int i = 0; i < 65536; i++) exp_bus(0, 1, i, 'h00F, 0);
        exp_bus(1, 1, 1027, 'h777, 1);
        tick();
        clr_start = 1'b0; clr_color = 12'h3C3;
        repeat (1000) tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (64535) tick();
        tick();
        wr_req = 1'b0;
        repeat (3) tick();

        // display steals a cycle mid-clear, then reset aborts it
        clr_start = 1'b1; clr_color = 12'h0A0;
        c = cyc;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 98; i++) exp_bus(0, 1, i, 'h0A0, 0);
        repeat (49) tick();
        vga_x = 16'd7; vga_y = 16'd3;
        chk(c + 50, 2, 0); chk(c + 50, 1, 775);
        chk(c + 52, 0, 'h00F);
        repeat (50) tick();
        rst = 1'b1;
        chk(c + 100, 2, 0);
        tick();
        rst = 1'b0;
        chk(c + 101, 4, 0); chk(c + 101, 5, 0);
        chk(c + 102, 5, 0);
        tick();

        // restart after reset begins at address 0
        clr_start = 1'b1; clr_color = 12'h0A5;
        c2 = cyc;
        chk(c2 + 1, 1, 0); chk(c2 + 1, 4, 1);
        for (int i = 0; i < 5; i++) exp_bus(0, 1, i, 'h0A5, 0);
        tick();
        clr_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(cyc, 4, 0);
        repeat (3) tick();

        cmp("bus_q_left", bus_q.size(), 0);
        cmp("chk_q_left", chk_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
